// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared pointer helpers for the async FIFO core
//
// Purpose:
//   Gray/binary conversion and pointer-width helper shared by the FIFO core.
//   Functions operate on the widest pointer the core supports
//   (P_DEPTH = 4096 -> 13 bits). Callers zero-extend narrower pointers on
//   the way in and truncate on the way out. Zero upper bits do not change
//   the low bits of either conversion.
//
// Contents:
//   C_DEPTH_MAX  largest supported entry count
//   C_PTR_MAX    width of the widest pointer
//   ptr_width()  pointer width for a given depth: $clog2(depth) + 1
//   bin2gray()   binary -> reflected Gray
//   gray2bin()   reflected Gray -> binary
//
// Configuration macro used by the core: ASYNC_FIFO_ILA_EN (debug core).

package async_fifo_pkg;

    localparam int C_DEPTH_MAX = 4096;
    localparam int C_PTR_MAX   = $clog2(C_DEPTH_MAX) + 1;

    // One extra bit beyond the address distinguishes full from empty.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic logic [C_PTR_MAX-1:0] bin2gray(input logic [C_PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [C_PTR_MAX-1:0] gray2bin(input logic [C_PTR_MAX-1:0] g);
        logic [C_PTR_MAX-1:0] b;
        b = g;
        for (int i = 1; i < C_PTR_MAX; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// rtl/fifo_ptr_sync.sv - two-flop synchronizer for a Gray-coded FIFO pointer
//
// Purpose:
//   Carries a Gray pointer into the opposite FIFO domain through two flops.
//   Only one bit of a Gray pointer changes per increment. A capture taken
//   mid-transition therefore resolves to either the old or the new value,
//   never to an unrelated one.
//
// Ports:
//   clk    in   destination-domain clock
//   rst_n  in   synchronous active-low reset, clears both stages
//   i_d    in   P_W  Gray pointer from the source domain
//   o_q    out  P_W  synchronized Gray pointer (two cycles behind i_d)

module fifo_ptr_sync #(
    parameter int P_W = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [P_W-1:0] i_d,
    output logic [P_W-1:0] o_q
);

    logic [P_W-1:0] r_meta;
    logic [P_W-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/async_fifo_core.sv
// rtl/async_fifo_core.sv - first-word-fall-through FIFO with Gray pointer crossing
//
// Purpose:
//   P_DEPTH x P_WIDTH FIFO built like a dual-clock FIFO but run on one clock.
//   Each side sees the other side's pointer through a 2-flop synchronizer.
//   Latency and full/empty behaviour therefore match the dual-clock variant.
//   Storage is a simple dual-port RAM with a registered read. That read
//   register is also the FWFT output stage.
//
// Parameters:
//   P_DEPTH  entry count, power of two, 4..4096
//   P_WIDTH  data word width
//
// Ports:
//   clk      in   sole clock, rising edge
//   rst_n    in   synchronous active-low reset
//   wr_data  in   P_WIDTH  write word
//   wr_vld   in   write request
//   wr_rdy   out  space available; push happens when wr_vld & wr_rdy
//   rd_data  out  P_WIDTH  head-of-queue word, 0 when rd_vld is low
//   rd_vld   out  head word valid
//   rd_rdy   in   read acknowledge; pop happens when rd_vld & rd_rdy
//
// Configuration:
//   ASYNC_FIFO_ILA_EN  when defined, adds an ila_0 debug core on clk.
//                      The core only observes and does not change behaviour.

module async_fifo_core
    import async_fifo_pkg::*;
#(
    parameter int P_DEPTH = 256,
    parameter int P_WIDTH = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [P_WIDTH-1:0] wr_data,
    input  logic               wr_vld,
    output logic               wr_rdy,
    output logic [P_WIDTH-1:0] rd_data,
    output logic               rd_vld,
    input  logic               rd_rdy
);

    localparam int              C_AW        = $clog2(P_DEPTH);
    localparam int              C_PW        = ptr_width(P_DEPTH);
    localparam logic [C_PW-1:0] C_FULL_DIST = C_PW'(P_DEPTH);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [P_WIDTH-1:0] r_mem [P_DEPTH];

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic            r_wr_en;    // low while in reset, high from the first cycle after
    logic [C_PW-1:0] r_wptr;
    logic [C_PW-1:0] r_wgray;
    logic [C_PW-1:0] w_wptr_nxt;
    logic [C_PW-1:0] w_rq2_rgray;
    logic [C_PW-1:0] w_rq2_rbin;
    logic            w_full;
    logic            w_wr_rdy;
    logic            w_push;

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    // r_rptr counts words that have left the FIFO through a pop. The head
    // word keeps its RAM slot until it is popped, so the write side never
    // sees more than P_DEPTH words of space.
    logic [C_PW-1:0]    r_rptr;
    logic [C_PW-1:0]    r_rgray;
    logic [C_PW-1:0]    w_rptr_nxt;
    logic [C_PW-1:0]    w_wq2_wgray;
    logic [C_PW-1:0]    w_wq2_wbin;
    logic [C_PW-1:0]    w_fetch;
    logic               w_has_next;
    logic               w_pop;
    logic               w_load;
    logic               r_rd_vld;
    logic [P_WIDTH-1:0] r_rd_data;

    // ------------------------------------------------------------------
    // Pointer crossing
    // ------------------------------------------------------------------
    fifo_ptr_sync #(
        .P_W (C_PW)
    ) u_sync_r2w (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (r_rgray),
        .o_q   (w_rq2_rgray)
    );

    fifo_ptr_sync #(
        .P_W (C_PW)
    ) u_sync_w2r (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (r_wgray),
        .o_q   (w_wq2_wgray)
    );

    // ------------------------------------------------------------------
    // Write side logic
    // ------------------------------------------------------------------
    assign w_wptr_nxt = r_wptr + C_PW'(1);
    assign w_rq2_rbin = C_PW'(gray2bin(C_PTR_MAX'(w_rq2_rgray)));

    // The synchronized read pointer lags the real one. This makes full
    // conservative: space freed by a pop shows up two cycles later.
    assign w_full   = ((r_wptr - w_rq2_rbin) == C_FULL_DIST);
    assign w_wr_rdy = r_wr_en & ~w_full;
    assign w_push   = wr_vld & w_wr_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en <= 1'b0;
            r_wptr  <= '0;
            r_wgray <= '0;
        end else begin
            r_wr_en <= 1'b1;
            if (w_push) begin
                r_wptr  <= w_wptr_nxt;
                // Gray is registered so the synchronizer input never glitches.
                r_wgray <= C_PW'(bin2gray(C_PTR_MAX'(w_wptr_nxt)));
            end
        end
    end

    // RAM write port. Contents are not cleared on reset because the pointers
    // alone decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[C_AW-1:0]] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Read side logic
    // ------------------------------------------------------------------
    assign w_wq2_wbin = C_PW'(gray2bin(C_PTR_MAX'(w_wq2_wgray)));
    assign w_rptr_nxt = r_rptr + C_PW'(1);

    // Next word to fetch sits one past the head when the head is held.
    assign w_fetch    = r_rptr + C_PW'(r_rd_vld);
    assign w_has_next = (w_wq2_wbin != w_fetch);
    assign w_pop      = r_rd_vld & rd_rdy;
    assign w_load     = w_has_next & (~r_rd_vld | rd_rdy);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rptr  <= '0;
            r_rgray <= '0;
        end else if (w_pop) begin
            r_rptr  <= w_rptr_nxt;
            r_rgray <= C_PW'(bin2gray(C_PTR_MAX'(w_rptr_nxt)));
        end
    end

    // Registered RAM read doubles as the FWFT output stage. It is cleared
    // whenever it empties so that rd_data reads 0 while rd_vld is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end else if (w_load) begin
            r_rd_vld  <= 1'b1;
            r_rd_data <= r_mem[w_fetch[C_AW-1:0]];
        end else if (w_pop) begin
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end
    end

    assign wr_rdy  = w_wr_rdy;
    assign rd_vld  = r_rd_vld;
    assign rd_data = r_rd_data;

    // ------------------------------------------------------------------
    // Optional debug core
    // ------------------------------------------------------------------
`ifdef ASYNC_FIFO_ILA_EN
    ila_0 u_ila (
        .clk    (clk),
        .probe0 (r_wptr),
        .probe1 (r_rptr),
        .probe2 (w_wr_rdy),
        .probe3 (r_rd_vld),
        .probe4 (wr_vld),
        .probe5 (rd_rdy),
        .probe6 (wr_data[7:0]),
        .probe7 (r_rd_data[7:0])
    );
`else
    // Default build: no debug instance.
`endif

endmodule

// File: tb/tb_async_fifo_core.sv
// tb/tb_async_fifo_core.sv - self-checking bench for async_fifo_core (depth 4 and depth 16 instances)

module tb_async_fifo_core;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Depth-4 instance
    logic [11:0] a_wd;
    logic        a_wv;
    logic        a_wr_rdy;
    logic [11:0] a_rd_data;
    logic        a_rd_vld;
    logic        a_rr;

    // Depth-16 instance
    logic [11:0] b_wd;
    logic        b_wv;
    logic        b_wr_rdy;
    logic [11:0] b_rd_data;
    logic        b_rd_vld;
    logic        b_rr;

    async_fifo_core #(.P_DEPTH(4), .P_WIDTH(12)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (a_wd),
        .wr_vld  (a_wv),
        .wr_rdy  (a_wr_rdy),
        .rd_data (a_rd_data),
        .rd_vld  (a_rd_vld),
        .rd_rdy  (a_rr)
    );

    async_fifo_core #(.P_DEPTH(16), .P_WIDTH(12)) u_dut16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_data (b_wd),
        .wr_vld  (b_wv),
        .wr_rdy  (b_wr_rdy),
        .rd_data (b_rd_data),
        .rd_vld  (b_rd_vld),
        .rd_rdy  (b_rr)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        wv;
        logic [11:0] wd;
        logic        rr;
        logic        ew;
        logic        ev;
        logic [11:0] ed;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required finish");
        $fatal(1);
    end

    initial begin
        int got[$];
        int q[$];
        int rdy_at;
        int waited;
        int extra;
        int pushed;
        int popped;
        int gaps;
        int stalls;
        bit started;
        bit push;
        bit pop;
        int wprob;
        int rprob;

        // inputs: wv, wd, rr | expected after the edge: wr_rdy, rd_vld, rd_data
        // Rows 0-6: single push of 0xABC into empty FIFO, rd_rdy held high.
        tbl[0]  = '{1'b1, 12'hABC, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[1]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[2]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[3]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b1, 12'hABC};
        tbl[4]  = '{1'b0, 12'h000, 1'b1, 1'b1, 1'b0, 12'h000};
        tbl[5]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000};
        tbl[6]  = '{1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000};
        // Rows 7-12: fill depth-4 with 1..4, then 0x5 must be refused.
        tbl[7]  = '{1'b1, 12'h001, 1'b0, 1'b1, 1'b0, 12'h000};
        tbl[8]  = '{1'b1, 12'h002, 1'b0, 1'b1, 1'b0, 12'h000};
        tbl[9]  = '{1'b1, 12'h003, 1'b0, 1'b1, 1'b0, 12'h000};
        tbl[10] = '{1'b1, 12'h004, 1'b0, 1'b0, 1'b1, 12'h001};
        tbl[11] = '{1'b1, 12'h005, 1'b0, 1'b0, 1'b1, 12'h001};
        tbl[12] = '{1'b1, 12'h005, 1'b0, 1'b0, 1'b1, 12'h001};

        a_wd = '0; a_wv = 1'b0; a_rr = 1'b0;
        b_wd = '0; b_wv = 1'b0; b_rr = 1'b0;

        // ---------------- reset ----------------
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_a_wr_rdy", 32'(a_wr_rdy), 0);
            chk("rst_a_rd_vld", 32'(a_rd_vld), 0);
            chk("rst_a_rd_data", 32'(a_rd_data), 0);
            chk("rst_b_wr_rdy", 32'(b_wr_rdy), 0);
            chk("rst_b_rd_vld", 32'(b_rd_vld), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_a_wr_rdy", 32'(a_wr_rdy), 1);
        chk("post_rst_a_rd_vld", 32'(a_rd_vld), 0);
        chk("post_rst_a_rd_data", 32'(a_rd_data), 0);
        chk("post_rst_b_wr_rdy", 32'(b_wr_rdy), 1);
        chk("post_rst_b_rd_vld", 32'(b_rd_vld), 0);

        // ---------------- table: latency + fill ----------------
        for (int i = 0; i < 13; i++) begin
            a_wv = tbl[i].wv;
            a_wd = tbl[i].wd;
            a_rr = tbl[i].rr;
            @(negedge clk);
            chk($sformatf("tbl%0d_wr_rdy", i), 32'(a_wr_rdy), 32'(tbl[i].ew));
            chk($sformatf("tbl%0d_rd_vld", i), 32'(a_rd_vld), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_rd_data", i), 32'(a_rd_data), 32'(tbl[i].ed));
        end

        // ---------------- drain the full depth-4 FIFO ----------------
        rdy_at = -1;
        for (int i = 0; i < 20; i++) begin
            if (a_wr_rdy && rdy_at < 0) rdy_at = i;
            if (a_rd_vld) got.push_back(int'(a_rd_data));
            else chk("drain_idle_data", 32'(a_rd_data), 0);
            a_wv = 1'b0;
            a_rr = 1'b1;
            @(negedge clk);
        end
        chk("drain_count", 32'(got.size()), 4);
        for (int k = 0; k < 4; k++)
            if (k < got.size()) chk($sformatf("drain_word%0d", k), 32'(got[k]), 32'(k + 1));
        chk("drain_wr_rdy_within_3", 32'(rdy_at >= 1 && rdy_at <= 4), 1);
        chk("drain_end_rd_vld", 32'(a_rd_vld), 0);
        a_rr = 1'b0;

        // ---------------- mid-operation reset on depth-16 ----------------
        for (int i = 0; i < 10; i++) begin
            chk("mid_fill_wr_rdy", 32'(b_wr_rdy), 1);
            b_wv = 1'b1;
            b_wd = 12'(12'h100 + i);
            b_rr = 1'b0;
            @(negedge clk);
        end
        b_wv = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_pre_rd_vld", 32'(b_rd_vld), 1);
        chk("mid_pre_rd_data", 32'(b_rd_data), 32'h100);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rd_vld", 32'(b_rd_vld), 0);
        chk("mid_rst_rd_data", 32'(b_rd_data), 0);
        chk("mid_rst_wr_rdy", 32'(b_wr_rdy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_after_wr_rdy", 32'(b_wr_rdy), 1);
        chk("mid_after_rd_vld", 32'(b_rd_vld), 0);
        b_wv = 1'b1;
        b_wd = 12'h007;
        @(negedge clk);
        b_wv = 1'b0;
        waited = 0;
        while (!b_rd_vld && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("mid_fresh_rd_vld", 32'(b_rd_vld), 1);
        chk("mid_fresh_rd_data", 32'(b_rd_data), 32'h007);
        chk("mid_fresh_latency", 32'(waited), 3);
        b_rr = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (b_rd_vld) extra++;
        end
        chk("mid_no_old_words", 32'(extra), 0);

        // ---------------- streaming 3*P_DEPTH words ----------------
        pushed = 0; popped = 0; gaps = 0; stalls = 0; started = 1'b0;
        for (int cyc = 0; cyc < 300 && popped < 48; cyc++) begin
            if (b_rd_vld) chk("stream_data", 32'(b_rd_data), 32'(popped));
            else begin
                chk("stream_idle_data", 32'(b_rd_data), 0);
                if (started) gaps++;
            end
            b_wv = (pushed < 48);
            b_wd = 12'(pushed);
            b_rr = 1'b1;
            if (b_wv && !b_wr_rdy) stalls++;
            if (b_wv && b_wr_rdy) pushed++;
            if (b_rd_vld) begin
                popped++;
                started = 1'b1;
            end
            @(negedge clk);
        end
        chk("stream_popped", 32'(popped), 48);
        chk("stream_gaps", 32'(gaps), 0);
        chk("stream_stalls", 32'(stalls), 0);
        b_wv = 1'b0;
        repeat (4) @(negedge clk);
        chk("stream_end_rd_vld", 32'(b_rd_vld), 0);

        // ---------------- random traffic against a queue model ----------------
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (b_rd_vld) begin
                chk("rand_nonempty", 32'(q.size() > 0), 1);
                if (q.size() > 0) chk("rand_data", 32'(b_rd_data), 32'(q[0]));
            end else begin
                chk("rand_idle_data", 32'(b_rd_data), 0);
            end
            if (!b_wr_rdy) chk("rand_full_occupancy", 32'(q.size() >= 4 && q.size() <= 16), 1);
            chk("rand_capacity", 32'(q.size() <= 16), 1);

            case ((cyc / 500) % 3)
                0:       begin wprob = 75; rprob = 30; end
                1:       begin wprob = 50; rprob = 50; end
                default: begin wprob = 30; rprob = 75; end
            endcase
            b_wv = ($urandom_range(0, 99) < wprob);
            b_wd = 12'($urandom);
            b_rr = ($urandom_range(0, 99) < rprob);
            push = b_wv && b_wr_rdy;
            pop  = b_rd_vld && b_rr;
            if (pop && q.size() > 0) void'(q.pop_front());
            if (push) q.push_back(int'(b_wd));
            @(negedge clk);
        end

        // Drain whatever remains.
        b_wv = 1'b0;
        b_rr = 1'b1;
        for (int cyc = 0; cyc < 100 && (q.size() > 0 || b_rd_vld); cyc++) begin
            if (b_rd_vld) begin
                chk("final_nonempty", 32'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    chk("final_data", 32'(b_rd_data), 32'(q[0]));
                    void'(q.pop_front());
                end
            end
            @(negedge clk);
        end
        chk("final_model_empty", 32'(q.size()), 0);
        repeat (4) @(negedge clk);
        chk("final_rd_vld", 32'(b_rd_vld), 0);
        chk("final_wr_rdy", 32'(b_wr_rdy), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/async_fifo_core.md
ASYNC_FIFO_CORE -- requirements
Module: async_fifo_core

Interface
REQ-001 SHALL have parameter P_DEPTH, default 256, entry count; power of two, 4..4096.
REQ-002 SHALL have parameter P_WIDTH, default 12, data word width in bits.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port wr_data, input, P_WIDTH, write word.
REQ-006 SHALL have port wr_vld, input, 1, write request.
REQ-007 SHALL have port wr_rdy, output, 1, space available.
REQ-008 SHALL have port rd_data, output, P_WIDTH, head-of-queue word.
REQ-009 SHALL have port rd_vld, output, 1, head word valid.
REQ-010 SHALL have port rd_rdy, input, 1, read acknowledge.

Function
REQ-011 SHALL push wr_data on a clk edge where wr_vld=1 and wr_rdy=1; wr_vld=1 with wr_rdy=0 is dropped, with no state change.
REQ-012 SHALL pop on a clk edge where rd_vld=1 and rd_rdy=1; rd_rdy=1 with rd_vld=0 is ignored.
REQ-013 SHALL be first-word-fall-through: rd_data equals the oldest stored word whenever rd_vld=1; rd_data=0 whenever rd_vld=0.
REQ-014 SHALL keep write and read pointers of log2(P_DEPTH)+1 bits, binary-incremented and Gray-encoded for crossing.
REQ-015 SHALL pass each Gray pointer to the opposite side through a 2-flop synchronizer, even in this single-clock build, so timing matches the dual-clock variant.
REQ-016 SHALL deassert wr_rdy when the write pointer minus the synchronized read pointer equals P_DEPTH; capacity is exactly P_DEPTH words.
REQ-017 SHALL assert rd_vld 3 clk cycles after the push of a word into an empty FIFO: 2 synchronizer cycles plus 1 output-register cycle.
REQ-018 SHALL reassert wr_rdy no later than 3 cycles after a pop from a full FIFO; full and empty are conservative and never indicate false space or false data.
REQ-019 SHALL support a simultaneous push and pop in one cycle, including at full, where the push is refused because wr_rdy=0 that cycle.
REQ-020 SHALL wrap pointers modulo 2*P_DEPTH without data loss or ordering error.
REQ-021 SHALL, with wr_vld=1 and rd_rdy=1 held constantly, stream every word through in order with a fixed latency.

Reset
REQ-022 SHALL, while rst_n=0, clear both pointers, all synchronizer flops and the output register, and drive wr_rdy=0, rd_vld=0 and rd_data=0.
REQ-023 SHALL drive wr_rdy=1 on the first cycle after rst_n rises.
REQ-024 SHALL discard all stored contents on a mid-operation reset; memory contents need no clearing.

Configuration
REQ-025 SHALL, when macro ASYNC_FIFO_ILA_EN is defined, instantiate debug core ila_0 clocked by clk, probing both pointers, wr_rdy, rd_vld, wr_vld, rd_rdy and the low 8 bits of wr_data and rd_data.
REQ-026 SHALL, without ASYNC_FIFO_ILA_EN, contain no debug instance; behaviour SHALL be identical with and without the macro.

Structure
REQ-027 SHALL place the bin2gray/gray2bin functions and the pointer-width helper ($clog2(P_DEPTH)+1) in shared package async_fifo_pkg.
REQ-028 SHALL implement the 2-flop pointer synchronizer as one sub-module, fifo_ptr_sync, parameterized by width and instantiated twice.
REQ-029 SHALL infer storage as simple dual-port RAM, with writes and registered reads on clk.

Verification
REQ-030 Reset: rst_n=0 for 4 cycles, then 1 -> rd_vld=0 and rd_data=0 throughout; wr_rdy=0 during reset and 1 on the first cycle after.
REQ-031 Latency: single push of 0xABC into the empty FIFO at cycle N -> rd_vld=1 and rd_data=0xABC at N+3; with rd_rdy=1, rd_vld=0 at N+4.
REQ-032 Fill: P_DEPTH=4, rd_rdy=0, push 0x1,0x2,0x3,0x4,0x5 -> wr_rdy=0 after the 4th push; 0x5 is dropped; draining yields 1,2,3,4 and then rd_vld=0.
REQ-033 Streaming: wr_vld=1 and rd_rdy=1 held, incrementing data for 3*P_DEPTH words -> output is the identical sequence across pointer wrap, with no gaps after the initial latency.
REQ-034 Mid-operation reset: with 10 words stored, pulse rst_n=0 for 1 cycle -> rd_vld=0 and rd_data=0 on the next cycle; a fresh push of 0x7 is the next word out.
REQ-035 Random traffic: random wr_vld and rd_rdy for 10k cycles, scoreboard compared -> no loss, no duplication, no reordering; wr_rdy=0 only when 4..P_DEPTH words are in flight.
